// File: rtl/rom_fetch_arbiter.sv
// rom_fetch_arbiter: shares one synchronous-read ROM port between the BG tile fetcher and the SPR fetcher
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_blank                      video blanking interval (SPR gets priority)
//   i_bg_req,  i_bg_addr         BG read request / address, held until granted
//   i_spr_req, i_spr_addr        SPR read request / address, held until granted
//   o_bg_gnt,  o_spr_gnt         combinational grants, at most one per cycle
//   o_bg_rvalid, o_spr_rvalid    o_rdata belongs to that requester this cycle
//   o_rom_addr, i_rom_rdata      ROM port (ROM registers the address, 1-cycle latency)
//   o_rdata                      unregistered pass-through of i_rom_rdata
//   o_spr_starved                sticky flag: SPR waited MAX_WAIT cycles since reset
module rom_fetch_arbiter #(
    parameter int ADDR_BITS = 10,
    parameter int DATA_BITS = 6,
    parameter int MAX_WAIT  = 3
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_blank,
    input  logic                 i_bg_req,
    input  logic [ADDR_BITS-1:0] i_bg_addr,
    output logic                 o_bg_gnt,
    output logic                 o_bg_rvalid,
    input  logic                 i_spr_req,
    input  logic [ADDR_BITS-1:0] i_spr_addr,
    output logic                 o_spr_gnt,
    output logic                 o_spr_rvalid,
    output logic [ADDR_BITS-1:0] o_rom_addr,
    input  logic [DATA_BITS-1:0] i_rom_rdata,
    output logic [DATA_BITS-1:0] o_rdata,
    output logic                 o_spr_starved
);
    typedef enum logic [1:0] {OWN_NONE, OWN_BG, OWN_SPR} own_t;
    localparam logic [3:0] W_MAX = 4'(MAX_WAIT);
    own_t       r_own;
    logic [3:0] r_wait_cnt;
    logic       r_starved;
    logic       w_spr_win;
    // SPR takes the port when it is alone, during blanking, or once it has waited MAX_WAIT cycles
    assign w_spr_win     = i_spr_req & (~i_bg_req | i_blank | (r_wait_cnt == W_MAX));
    assign o_spr_gnt     = ~i_rst & w_spr_win;
    assign o_bg_gnt      = ~i_rst & i_bg_req & ~w_spr_win;
    assign o_rom_addr    = o_spr_gnt ? i_spr_addr : o_bg_gnt ? i_bg_addr : '0;
    assign o_rdata       = i_rom_rdata;
    assign o_bg_rvalid   = r_own == OWN_BG;
    assign o_spr_rvalid  = r_own == OWN_SPR;
    assign o_spr_starved = r_starved;
    // Owner of the read in flight: the ROM answers one cycle after the grant
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_own      <= OWN_NONE;
            r_wait_cnt <= '0;
            r_starved  <= 1'b0;
        end else begin
            r_own      <= o_spr_gnt ? OWN_SPR : o_bg_gnt ? OWN_BG : OWN_NONE;
            r_starved  <= r_starved | (r_wait_cnt == W_MAX);
            r_wait_cnt <= o_spr_gnt ? 4'd0 :
                          !i_spr_req ? r_wait_cnt :
                          (r_wait_cnt == W_MAX) ? W_MAX : r_wait_cnt + 4'd1;
        end
    end
endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// tb_rom_fetch_arbiter: directed and randomized checks of rom_fetch_arbiter against a behavioural model
module tb_rom_fetch_arbiter;
    localparam int AW = 10;
    localparam int DW = 6;
    localparam int MW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          blank = 1'b0;
    logic          bg_req = 1'b0, spr_req = 1'b0;
    logic [AW-1:0] bg_addr = '0, spr_addr = '0;
    logic          bg_gnt, spr_gnt, bg_rvalid, spr_rvalid, spr_starved;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_rdata, rdata;
    logic [DW-1:0] rom [0:(1<<AW)-1];

    int vectors = 0;
    int miscompares = 0;

    // reference model state: what the arbiter should hold after the next edge
    bit        m_known = 0;
    int        m_own = 0;
    int        m_addr = 0;
    int        m_wait = 0;
    bit        m_starved = 0;

    rom_fetch_arbiter #(.ADDR_BITS(AW), .DATA_BITS(DW), .MAX_WAIT(MW)) dut (
        .i_clk(clk), .i_rst(rst), .i_blank(blank),
        .i_bg_req(bg_req), .i_bg_addr(bg_addr), .o_bg_gnt(bg_gnt), .o_bg_rvalid(bg_rvalid),
        .i_spr_req(spr_req), .i_spr_addr(spr_addr), .o_spr_gnt(spr_gnt), .o_spr_rvalid(spr_rvalid),
        .o_rom_addr(rom_addr), .i_rom_rdata(rom_rdata), .o_rdata(rdata), .o_spr_starved(spr_starved)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) rom_rdata <= rom[rom_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one cycle: drive at negedge, check just after, then advance the model past the posedge
    task automatic step(input bit r, input bit bl, input bit bq, input int ba, input bit sq, input int sa);
        bit eb, es;
        int ea;
        @(negedge clk);
        rst = r; blank = bl; bg_req = bq; bg_addr = AW'(ba); spr_req = sq; spr_addr = AW'(sa);
        #1;
        es = !r && sq && (!bq || bl || m_wait == MW);
        eb = !r && bq && !es;
        ea = es ? sa : eb ? ba : 0;
        chk("bg_gnt", 32'(bg_gnt), 32'(eb));
        chk("spr_gnt", 32'(spr_gnt), 32'(es));
        chk("rom_addr", 32'(rom_addr), 32'(ea));
        if (m_known) begin
            chk("bg_rvalid", 32'(bg_rvalid), 32'(m_own == 1));
            chk("spr_rvalid", 32'(spr_rvalid), 32'(m_own == 2));
            chk("spr_starved", 32'(spr_starved), 32'(m_starved));
            if (m_own != 0) chk("rdata", 32'(rdata), 32'(rom[m_addr]));
        end
        if (r) begin
            m_known = 1; m_own = 0; m_wait = 0; m_starved = 0;
        end else begin
            m_own = es ? 2 : eb ? 1 : 0;
            m_addr = ea;
            if (m_wait == MW) m_starved = 1;
            m_wait = es ? 0 : sq ? ((m_wait + 1 > MW) ? MW : m_wait + 1) : m_wait;
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) rom[i] = DW'($urandom);
        rom[10'h02A] = 6'b110011;
        // 1: reset held with both requests, then BG wins first cycle out of reset
        for (int i = 0; i < 3; i++) step(1, 0, 1, 10'h011, 1, 10'h022);
        chk("t1_rst_gnt", 32'({bg_gnt, spr_gnt}), 32'd0);
        step(0, 0, 1, 10'h011, 1, 10'h022);
        chk("t1_first_bg", 32'(bg_gnt), 32'd1);
        // 2: single BG read
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 10'h02A, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("t2_rdata", 32'(rdata), 32'h33);
        chk("t2_rvalid", 32'(bg_rvalid), 32'd1);
        // 3: contention without blanking; SPR forced through on the 4th cycle
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 10'h050 + i, 1, 10'h200);
        chk("t3_spr_forced", 32'(spr_gnt), 32'd1);
        step(0, 0, 0, 0, 0, 0);
        chk("t3_starved", 32'(spr_starved), 32'd1);
        // 4: blanking gives SPR priority
        for (int i = 0; i < 6; i++) step(0, 1, 1, 10'h100 + (i & 1), 1, 10'h101 - (i & 1));
        step(0, 0, 0, 0, 0, 0);
        // 5: BG streaming
        for (int i = 0; i < 8; i++) step(0, 0, 1, i, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        // 6: reset right after an SPR grant discards its data and clears the wait count
        step(0, 0, 0, 0, 1, 10'h3FF);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("t6_no_rvalid", 32'(spr_rvalid), 32'd0);
        step(0, 0, 1, 10'h033, 1, 10'h044);
        chk("t6_wait_cleared", 32'(bg_gnt), 32'd1);
        // randomized traffic
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 40) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0,
                 int'($urandom_range(0, (1 << AW) - 1)), $urandom_range(0, 1) == 1,
                 int'($urandom_range(0, (1 << AW) - 1)));
        step(0, 0, 0, 0, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
